// File: rtl/lock_sequencer.sv
// lock_sequencer: single-clock controller for the password lock.
//
// The set and check buttons each go through a three-flop chain. A button acts
// when it is released, and that release is decoded from the last two flops of
// the chain. One state register holds the lock mode. The password is stored
// here and can be changed from OPENED through SET_AWAITING. OPENED relocks on
// its own after OPEN_CYCLES clocks (a value of 0 disables this). Consecutive
// wrong codes are counted, and when the count reaches MAX_FAILS the lock enters
// a timed LOCKOUT.
//
// Compile-time option:
//   FAIL_LOCKOUT_EN  defined   -> fail counter and LOCKOUT are active
//                    undefined -> every mismatch goes to ALARM;
//                                 fail_count and locked_out are tied to 0
//
// Parameters:
//   PW_WIDTH        password / code width in bits
//   RESET_PW        password loaded by reset
//   OPEN_CYCLES     clocks spent in OPENED before auto-relock (0 = never)
//   LOCKOUT_CYCLES  clocks spent in LOCKOUT (>= 1)
//   MAX_FAILS       consecutive mismatches that trigger LOCKOUT (1..3)
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   set_btn     raw set button, asynchronous, 1 = pressed, acts on release
//   check_btn   raw check button, asynchronous, 1 = pressed, acts on release
//   code_in     code or new password, sampled on the edge that commits a release
//   state       current state encoding
//   unlocked    high in OPENED
//   alarm       high in ALARM or LOCKOUT
//   locked_out  high in LOCKOUT
//   fail_count  consecutive mismatch count

module lock_sequencer #(
  parameter int unsigned         PW_WIDTH       = 7,
  parameter logic [PW_WIDTH-1:0] RESET_PW       = '0,
  parameter logic [15:0]         OPEN_CYCLES    = 16'd50000,
  parameter logic [15:0]         LOCKOUT_CYCLES = 16'd65535,
  parameter int unsigned         MAX_FAILS      = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_btn,
  input  logic                check_btn,
  input  logic [PW_WIDTH-1:0] code_in,
  output logic [2:0]          state,
  output logic                unlocked,
  output logic                alarm,
  output logic                locked_out,
  output logic [1:0]          fail_count
);

  typedef enum logic [2:0] {
    StIdle          = 3'd0,
    StSetAwaiting   = 3'd1,
    StOpened        = 3'd2,
    StAlarm         = 3'd3,
    StInputPassword = 3'd4,
    StLockout       = 3'd5
  } state_e;

  // Reject parameter values that the counter and timer cannot represent.
  if (MAX_FAILS < 1 || MAX_FAILS > 3 || LOCKOUT_CYCLES == 16'd0) begin : g_param_check
    $error("lock_sequencer: MAX_FAILS must be 1..3 and LOCKOUT_CYCLES >= 1");
  end

  localparam logic [15:0] OpenLoad = OPEN_CYCLES - 16'd1;

  // ---------------------------------------------------------------------------
  // Button synchronisers: bit 0 = s1, bit 1 = s2, bit 2 = s3.
  // These flops reset to 0, so a button held through reset looks like a fresh
  // press and produces a release only when it is actually let go.
  // ---------------------------------------------------------------------------
  logic [2:0] set_sync_q;
  logic [2:0] chk_sync_q;
  logic       set_rel;
  logic       check_rel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_sync_q <= '0;
      chk_sync_q <= '0;
    end else begin
      set_sync_q <= {set_sync_q[1:0], set_btn};
      chk_sync_q <= {chk_sync_q[1:0], check_btn};
    end
  end

  assign set_rel   = set_sync_q[2] & ~set_sync_q[1];
  assign check_rel = chk_sync_q[2] & ~chk_sync_q[1];

  // ---------------------------------------------------------------------------
  // State, password and timer registers
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [PW_WIDTH-1:0] pw_q, pw_d;
  logic [15:0]         timer_q, timer_d;

`ifdef FAIL_LOCKOUT_EN
  localparam logic [15:0] LockoutLoad = LOCKOUT_CYCLES - 16'd1;
  localparam logic [1:0]  FailLimit   = 2'(MAX_FAILS);

  logic [1:0] fail_q, fail_d;
  logic [1:0] fail_inc;

  // Saturating increment. Reaching the limit also moves the lock to LOCKOUT,
  // which then clears the count.
  assign fail_inc = (fail_q == FailLimit) ? fail_q : fail_q + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q <= '0;
    end else begin
      fail_q <= fail_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pw_q    <= RESET_PW;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      pw_q    <= pw_d;
      timer_q <= timer_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. check_rel is tested first so that it wins over set_rel,
  // except in SET_AWAITING, where a set release commits the password.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    timer_d = timer_q;
`ifdef FAIL_LOCKOUT_EN
    fail_d  = fail_q;
`endif

    case (state_q)
      StIdle: begin
        if (check_rel) begin
          state_d = StInputPassword;
        end
      end

      StInputPassword: begin
        if (check_rel) begin
          if (code_in == pw_q) begin
            state_d = StOpened;
            timer_d = OpenLoad;
`ifdef FAIL_LOCKOUT_EN
            fail_d  = '0;
`endif
          end else begin
`ifdef FAIL_LOCKOUT_EN
            fail_d = fail_inc;
            if (fail_inc == FailLimit) begin
              state_d = StLockout;
              timer_d = LockoutLoad;
            end else begin
              state_d = StAlarm;
            end
`else
            state_d = StAlarm;
`endif
          end
        end
      end

      StOpened: begin
        // A button release in the same cycle as expiry takes precedence.
        if (check_rel) begin
          state_d = StIdle;
        end else if (set_rel) begin
          state_d = StSetAwaiting;
        end else if (OPEN_CYCLES != 16'd0 && timer_q == 16'd0) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      StSetAwaiting: begin
        if (set_rel) begin
          pw_d    = code_in;
          state_d = StIdle;
        end else if (check_rel) begin
          state_d = StIdle;
        end
      end

      StAlarm: begin
        if (check_rel) begin
          state_d = StIdle;
        end
      end

      StLockout: begin
        // Both buttons are ignored here; only the timer can end LOCKOUT.
        if (timer_q == 16'd0) begin
          state_d = StIdle;
`ifdef FAIL_LOCKOUT_EN
          fail_d  = '0;
`endif
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Status decodes
  // ---------------------------------------------------------------------------
  assign state    = state_q;
  assign unlocked = (state_q == StOpened);
  assign alarm    = (state_q == StAlarm) || (state_q == StLockout);

`ifdef FAIL_LOCKOUT_EN
  assign locked_out = (state_q == StLockout);
  assign fail_count = fail_q;
`else
  assign locked_out = 1'b0;
  assign fail_count = 2'd0;
`endif

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed testbench for lock_sequencer with OPEN_CYCLES=8, LOCKOUT_CYCLES=20,
// MAX_FAILS=3 and RESET_PW=0. The bench runs the lockout scenario when
// FAIL_LOCKOUT_EN is defined. Otherwise it runs the no-lockout scenario.
// Inputs are driven, and outputs sampled, 1 time unit after each rising edge.
// st packs {state, unlocked, alarm, locked_out, fail_count}.

module tb_lock_sequencer;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       set_btn   = 1'b0;
  logic       check_btn = 1'b0;
  logic [6:0] code_in   = 7'h00;
  logic [2:0] state;
  logic       unlocked;
  logic       alarm;
  logic       locked_out;
  logic [1:0] fail_count;
  logic [7:0] st;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef FAIL_LOCKOUT_EN
  localparam bit LockoutEn = 1'b1;
`else
  localparam bit LockoutEn = 1'b0;
`endif

  always #5 clk = ~clk;

  assign st = {state, unlocked, alarm, locked_out, fail_count};

  lock_sequencer #(
    .PW_WIDTH      (7),
    .RESET_PW      (7'd0),
    .OPEN_CYCLES   (16'd8),
    .LOCKOUT_CYCLES(16'd20),
    .MAX_FAILS     (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_btn   (set_btn),
    .check_btn (check_btn),
    .code_in   (code_in),
    .state     (state),
    .unlocked  (unlocked),
    .alarm     (alarm),
    .locked_out(locked_out),
    .fail_count(fail_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold for 3 edges, release, then wait through E0, E1 and the commit edge E2.
  task automatic pulse(input bit s, input bit c);
    set_btn   = s;
    check_btn = c;
    repeat (3) tick();
    set_btn   = 1'b0;
    check_btn = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic enter_opened(input logic [6:0] pw);
    pulse(1'b0, 1'b1);
    code_in = pw;
    pulse(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    code_in = 7'h00;
    tick();
    tests_run++;
    if (st !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_status got %h exp %h", st, 8'h00);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_open_relock();
    pulse(1'b0, 1'b1);
    tests_run++;
    if (state !== 3'd4) begin
      tests_failed++;
      $display("FAIL t1_input state got %0d exp 4", state);
    end
    code_in   = 7'h00;
    check_btn = 1'b1;
    repeat (3) tick();
    check_btn = 1'b0;
    tick();
    tick();
    tests_run++;
    if (state !== 3'd4) begin
      tests_failed++;
      $display("FAIL t1_no_commit_e1 state got %0d exp 4", state);
    end
    tick();
    tests_run++;
    if (st !== {3'd2, 3'b100, 2'd0}) begin
      tests_failed++;
      $display("FAIL t1_opened_e2 got %h exp %h", st, {3'd2, 3'b100, 2'd0});
    end
    repeat (7) tick();
    tests_run++;
    if (st !== {3'd2, 3'b100, 2'd0}) begin
      tests_failed++;
      $display("FAIL t1_still_open_7 got %h exp %h", st, {3'd2, 3'b100, 2'd0});
    end
    tick();
    tests_run++;
    if (st !== 8'h00) begin
      tests_failed++;
      $display("FAIL t1_relock_8 got %h exp %h", st, 8'h00);
    end
  endtask

  task automatic test_set_password();
    enter_opened(7'h00);
    pulse(1'b1, 1'b0);
    tests_run++;
    if (state !== 3'd1) begin
      tests_failed++;
      $display("FAIL t2_set_await state got %0d exp 1", state);
    end
    code_in = 7'h5A;
    pulse(1'b1, 1'b0);
    tests_run++;
    if (state !== 3'd0) begin
      tests_failed++;
      $display("FAIL t2_set_commit state got %0d exp 0", state);
    end
    enter_opened(7'h5A);
    tests_run++;
    if (st !== {3'd2, 3'b100, 2'd0}) begin
      tests_failed++;
      $display("FAIL t2_new_pw_open got %h exp %h", st, {3'd2, 3'b100, 2'd0});
    end
    pulse(1'b0, 1'b1);
    enter_opened(7'h00);
    tests_run++;
    if (st !== {3'd3, 3'b010, (LockoutEn ? 2'd1 : 2'd0)}) begin
      tests_failed++;
      $display("FAIL t2_old_pw_alarm got %h exp %h", st,
               {3'd3, 3'b010, (LockoutEn ? 2'd1 : 2'd0)});
    end
    pulse(1'b0, 1'b1);
    tests_run++;
    if (st !== {3'd0, 3'b000, (LockoutEn ? 2'd1 : 2'd0)}) begin
      tests_failed++;
      $display("FAIL t2_alarm_clear got %h exp %h", st,
               {3'd0, 3'b000, (LockoutEn ? 2'd1 : 2'd0)});
    end
  endtask

  task automatic test_lockout();
    do_reset();
    for (int i = 1; i <= 2; i++) begin
      enter_opened(7'h11);
      tests_run++;
      if (st !== {3'd3, 3'b010, 2'(i)}) begin
        tests_failed++;
        $display("FAIL t3_alarm_%0d got %h exp %h", i, st, {3'd3, 3'b010, 2'(i)});
      end
      pulse(1'b0, 1'b1);
    end
    enter_opened(7'h11);
    tests_run++;
    if (st !== {3'd5, 3'b011, 2'd3}) begin
      tests_failed++;
      $display("FAIL t3_lockout_entry got %h exp %h", st, {3'd5, 3'b011, 2'd3});
    end
    pulse(1'b0, 1'b1);
    tests_run++;
    if (state !== 3'd5) begin
      tests_failed++;
      $display("FAIL t3_ignore_check state got %0d exp 5", state);
    end
    pulse(1'b1, 1'b0);
    tests_run++;
    if (state !== 3'd5) begin
      tests_failed++;
      $display("FAIL t3_ignore_set state got %0d exp 5", state);
    end
    repeat (7) tick();
    tests_run++;
    if (st !== {3'd5, 3'b011, 2'd3}) begin
      tests_failed++;
      $display("FAIL t3_lockout_19 got %h exp %h", st, {3'd5, 3'b011, 2'd3});
    end
    tick();
    tests_run++;
    if (st !== 8'h00) begin
      tests_failed++;
      $display("FAIL t3_lockout_exit got %h exp %h", st, 8'h00);
    end
  endtask

  task automatic test_no_lockout();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      enter_opened(7'h11);
      tests_run++;
      if (st !== {3'd3, 3'b010, 2'd0}) begin
        tests_failed++;
        $display("FAIL t6_alarm_%0d got %h exp %h", i, st, {3'd3, 3'b010, 2'd0});
      end
      pulse(1'b0, 1'b1);
    end
    tests_run++;
    if (st !== 8'h00) begin
      tests_failed++;
      $display("FAIL t6_final_idle got %h exp %h", st, 8'h00);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    enter_opened(7'h00);
    code_in = 7'h33;
    pulse(1'b1, 1'b1);
    tests_run++;
    if (state !== 3'd0) begin
      tests_failed++;
      $display("FAIL t4_opened_both state got %0d exp 0", state);
    end
    enter_opened(7'h00);
    tests_run++;
    if (state !== 3'd2) begin
      tests_failed++;
      $display("FAIL t4_pw_unchanged state got %0d exp 2", state);
    end
    pulse(1'b1, 1'b0);
    code_in = 7'h33;
    pulse(1'b1, 1'b1);
    tests_run++;
    if (state !== 3'd0) begin
      tests_failed++;
      $display("FAIL t4_await_both state got %0d exp 0", state);
    end
    enter_opened(7'h33);
    tests_run++;
    if (state !== 3'd2) begin
      tests_failed++;
      $display("FAIL t4_set_wins state got %0d exp 2", state);
    end
    // Arrange for the check release to commit on the 8th edge, when timer==0.
    tick();
    tick();
    check_btn = 1'b1;
    repeat (3) tick();
    check_btn = 1'b0;
    tick();
    tick();
    tests_run++;
    if (state !== 3'd2) begin
      tests_failed++;
      $display("FAIL t4_edge7 state got %0d exp 2", state);
    end
    tick();
    tests_run++;
    if (state !== 3'd0) begin
      tests_failed++;
      $display("FAIL t4_expiry_check state got %0d exp 0", state);
    end
    repeat (4) tick();
    tests_run++;
    if (state !== 3'd0) begin
      tests_failed++;
      $display("FAIL t4_exactly_once state got %0d exp 0", state);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enter_opened(7'h00);
    pulse(1'b1, 1'b0);
    code_in = 7'h5A;
    pulse(1'b1, 1'b0);
    enter_opened(7'h5A);
    tick();
    tick();
    tests_run++;
    if (state !== 3'd2) begin
      tests_failed++;
      $display("FAIL t5_opened_pre state got %0d exp 2", state);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (st !== 8'h00) begin
      tests_failed++;
      $display("FAIL t5_async_clear got %h exp %h", st, 8'h00);
    end
    check_btn = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    tests_run++;
    if (state !== 3'd0) begin
      tests_failed++;
      $display("FAIL t5_held_btn state got %0d exp 0", state);
    end
    check_btn = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (state !== 3'd4) begin
      tests_failed++;
      $display("FAIL t5_btn_fall state got %0d exp 4", state);
    end
    code_in = 7'h00;
    pulse(1'b0, 1'b1);
    tests_run++;
    if (state !== 3'd2) begin
      tests_failed++;
      $display("FAIL t5_pw_reset state got %0d exp 2", state);
    end
  endtask

  initial begin
    test_reset();
    test_open_relock();
    test_set_password();
`ifdef FAIL_LOCKOUT_EN
    test_lockout();
`else
    test_no_lockout();
`endif
    test_simultaneous();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
